// File: rtl/cordic_quadrant_fold_pkg.sv
// Shared types for the CORDIC quadrant fold wrapper.
// Contents: FSM state encoding and the 2-bit quadrant index type.
// No ports; imported by the top and the sign/swap sub-module.
package cordic_quadrant_fold_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ARM   = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_t;

endpackage

// File: rtl/cordic_quadrant_fold_if.sv
// Bundle of request, result and core-side signals around the quadrant fold.
// slave  : view of the fold block (takes requests and core results, drives results and core controls).
// master : view of the surrounding environment (requester, consumer and CORDIC core).
interface cordic_quadrant_fold_if #(
  parameter int BIT_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [BIT_WIDTH+1:0] in_angle;
  logic                 core_start;
  logic [BIT_WIDTH-1:0] core_target;
  logic                 core_done;
  logic [BIT_WIDTH-1:0] core_x;
  logic [BIT_WIDTH-1:0] core_y;
  logic                 out_valid;
  logic                 out_ready;
  logic [BIT_WIDTH:0]   out_cos;
  logic [BIT_WIDTH:0]   out_sin;
  logic                 out_err;

  modport slave (
    input  in_valid, in_angle, core_done, core_x, core_y, out_ready,
    output in_ready, core_start, core_target, out_valid, out_cos, out_sin, out_err
  );

  modport master (
    output in_valid, in_angle, core_done, core_x, core_y, out_ready,
    input  in_ready, core_start, core_target, out_valid, out_cos, out_sin, out_err
  );
endinterface

// File: rtl/cordic_quadrant_fold_quad_sign.sv
// Combinational quadrant unfold: swaps and negates first-quadrant magnitudes.
// Ports: q (quadrant), core_x/core_y (|cos f|, |sin f|) in; cos/sin signed BIT_WIDTH+1 out.
// Magnitudes are zero-extended by one bit so the largest value negates without overflow.
module cordic_quadrant_fold_quad_sign
  import cordic_quadrant_fold_pkg::*;
#(
  parameter int BIT_WIDTH = 8
) (
  input  quadrant_t            q,
  input  logic [BIT_WIDTH-1:0] core_x,
  input  logic [BIT_WIDTH-1:0] core_y,
  output logic [BIT_WIDTH:0]   cos,
  output logic [BIT_WIDTH:0]   sin
);
  logic [BIT_WIDTH:0] x_pos;
  logic [BIT_WIDTH:0] y_pos;
  logic [BIT_WIDTH:0] x_neg;
  logic [BIT_WIDTH:0] y_neg;

  assign x_pos = {1'b0, core_x};
  assign y_pos = {1'b0, core_y};
  assign x_neg = (~x_pos) + 1'b1;
  assign y_neg = (~y_pos) + 1'b1;

  always_comb begin
    cos = x_pos;
    sin = y_pos;
    case (q)
      Q0: begin cos = x_pos; sin = y_pos; end
      Q1: begin cos = y_neg; sin = x_pos; end
      Q2: begin cos = x_neg; sin = y_neg; end
      Q3: begin cos = y_pos; sin = x_neg; end
      default: begin cos = x_pos; sin = y_pos; end
    endcase
  end
endmodule

// File: rtl/cordic_quadrant_fold.sv
// Folds a full-circle angle into quadrant 0 for a first-quadrant CORDIC core, then unfolds the result.
// Ports: clk, reset_n (async, active-low), io (slave view: angle request, core control/result, signed cos/sin result).
// One op at a time; a watchdog ends a WAIT that lasts TIMEOUT_CYCLES with out_err=1 and zero outputs.
module cordic_quadrant_fold
  import cordic_quadrant_fold_pkg::*;
#(
  parameter int BIT_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  cordic_quadrant_fold_if.slave io
);
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t               state;
  quadrant_t            quad;
  logic [CNT_W-1:0]     wdog;
  logic                 in_ready_r;
  logic                 start_r;
  logic [BIT_WIDTH-1:0] target_r;
  logic                 out_valid_r;
  logic [BIT_WIDTH:0]   cos_r;
  logic [BIT_WIDTH:0]   sin_r;
  logic                 err_r;
  logic [BIT_WIDTH:0]   fold_cos;
  logic [BIT_WIDTH:0]   fold_sin;

  cordic_quadrant_fold_quad_sign #(
    .BIT_WIDTH(BIT_WIDTH)
  ) u_quad_sign (
    .q      (quad),
    .core_x (io.core_x),
    .core_y (io.core_y),
    .cos    (fold_cos),
    .sin    (fold_sin)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      quad        <= Q0;
      wdog        <= '0;
      in_ready_r  <= 1'b1;
      start_r     <= 1'b0;
      target_r    <= '0;
      out_valid_r <= 1'b0;
      cos_r       <= '0;
      sin_r       <= '0;
      err_r       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid && in_ready_r) begin
            quad       <= quadrant_t'(io.in_angle[BIT_WIDTH+1:BIT_WIDTH]);
            target_r   <= io.in_angle[BIT_WIDTH-1:0];
            in_ready_r <= 1'b0;
            start_r    <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          start_r <= 1'b0;
          wdog    <= '0;
          state   <= ARM;
        end
        // core_done may still be high from the previous op; give the core
        // one cycle to drop it before it is trusted.
        ARM: begin
          state <= WAIT;
        end
        WAIT: begin
          if (io.core_done) begin
            cos_r       <= fold_cos;
            sin_r       <= fold_sin;
            err_r       <= 1'b0;
            out_valid_r <= 1'b1;
            state       <= HOLD;
          end else if (wdog == WDOG_LAST) begin
            cos_r       <= '0;
            sin_r       <= '0;
            err_r       <= 1'b1;
            out_valid_r <= 1'b1;
            state       <= HOLD;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        HOLD: begin
          if (io.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_r  <= 1'b1;
          start_r     <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign io.in_ready    = in_ready_r;
  assign io.core_start  = start_r;
  assign io.core_target = target_r;
  assign io.out_valid   = out_valid_r;
  assign io.out_cos     = cos_r;
  assign io.out_sin     = sin_r;
  assign io.out_err     = err_r;
endmodule

// File: tb/tb_cordic_quadrant_fold.sv
// Directed bench for cordic_quadrant_fold with a programmable-latency core model.
// Inputs are driven and outputs sampled on the falling edge.
module tb_cordic_quadrant_fold;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  cordic_quadrant_fold_if #(.BIT_WIDTH(8)) io();

  cordic_quadrant_fold #(
    .BIT_WIDTH(8),
    .TIMEOUT_CYCLES(64),
    .CNT_W(7)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (io)
  );

  // Core model: done rises 'lat' rising edges after the start pulse is seen.
  // lat < 0 never completes; sticky keeps a previous done high across ops.
  logic       mdone  = 1'b0;
  logic [7:0] mx     = 8'h00;
  logic [7:0] my     = 8'h00;
  int         lat    = -1;
  int         cnt    = 0;
  bit         sticky = 1'b0;

  assign io.core_done = mdone;
  assign io.core_x    = mx;
  assign io.core_y    = my;

  always @(posedge clk) begin
    if (io.core_start) begin
      if (!sticky) mdone <= 1'b0;
      cnt <= lat;
    end else if (cnt > 1) begin
      cnt <= cnt - 1;
    end else if (cnt == 1) begin
      mdone <= 1'b1;
      cnt   <= 0;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] q, input logic [7:0] f);
    int n;
    n = 0;
    @(negedge clk);
    while (!io.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_in_ready", {31'd0, io.in_ready}, 32'd1);
    io.in_valid = 1'b1;
    io.in_angle = {q, f};
    @(negedge clk);
    io.in_valid = 1'b0;
  endtask

  // Returns cycles from the core_start cycle to the first out_valid cycle.
  task automatic wait_out(output int latency, output int starts);
    int sc;
    sc = 0;
    starts = 0;
    latency = -1;
    for (int n = 0; n < 300; n++) begin
      if (io.core_start) begin
        starts++;
        sc = n;
      end
      if (io.out_valid) begin
        latency = n - sc;
        break;
      end
      @(negedge clk);
    end
    chk("out_valid_seen", {31'd0, io.out_valid}, 32'd1);
  endtask

  task automatic accept(input string tag);
    io.out_ready = 1'b1;
    @(negedge clk);
    io.out_ready = 1'b0;
    chk({tag, "_vld_drop"}, {31'd0, io.out_valid}, 32'd0);
    chk({tag, "_rdy_back"}, {31'd0, io.in_ready}, 32'd1);
  endtask

  task automatic op(input string tag, input logic [1:0] q, input logic [7:0] f,
                    input logic [7:0] x, input logic [7:0] y, input int l,
                    input logic [8:0] ecos, input logic [8:0] esin, input logic eerr,
                    input int elat);
    int got_lat;
    int got_starts;
    mx  = x;
    my  = y;
    lat = l;
    send(q, f);
    wait_out(got_lat, got_starts);
    chk({tag, "_latency"}, got_lat, elat);
    chk({tag, "_starts"}, got_starts, 1);
    chk({tag, "_target"}, {24'd0, io.core_target}, {24'd0, f});
    chk({tag, "_cos"}, {23'd0, io.out_cos}, {23'd0, ecos});
    chk({tag, "_sin"}, {23'd0, io.out_sin}, {23'd0, esin});
    chk({tag, "_err"}, {31'd0, io.out_err}, {31'd0, eerr});
    accept(tag);
  endtask

  initial begin
    int got_lat;
    int got_starts;
    reset_n      = 1'b0;
    io.in_valid  = 1'b0;
    io.in_angle  = '0;
    io.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, io.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, io.out_valid}, 32'd0);
    chk("rst_core_start", {31'd0, io.core_start}, 32'd0);
    chk("rst_target", {24'd0, io.core_target}, 32'd0);
    chk("rst_cos_sin_err", {14'd0, io.out_cos, io.out_sin, io.out_err}, 32'd0);
    reset_n = 1'b1;

    // Quadrant mapping; latency is core latency + START + ARM.
    op("q0", 2'd0, 8'h40, 8'hB5, 8'h4B, 10, 9'h0B5, 9'h04B, 1'b0, 12);
    op("q1", 2'd1, 8'h20, 8'hF0, 8'h30, 4,  9'h1D0, 9'h0F0, 1'b0, 6);
    op("q2", 2'd2, 8'h05, 8'h10, 8'h00, 1,  9'h1F0, 9'h000, 1'b0, 3);
    op("q3", 2'd3, 8'h7F, 8'h10, 8'h00, 2,  9'h000, 9'h1F0, 1'b0, 4);
    op("q2max", 2'd2, 8'hFF, 8'hFF, 8'hFF, 1, 9'h101, 9'h101, 1'b0, 3);

    // Hung core: START + ARM + 64 WAIT cycles.
    op("tmo", 2'd1, 8'h10, 8'h55, 8'h66, -1, 9'h000, 9'h000, 1'b1, 66);

    // Stale done: done stays high after op A; result held 5 cycles.
    sticky = 1'b1;
    mx  = 8'h12;
    my  = 8'h34;
    lat = 3;
    send(2'd0, 8'h11);
    wait_out(got_lat, got_starts);
    chk("stA_latency", got_lat, 5);
    chk("stA_cos", {23'd0, io.out_cos}, 32'h012);
    chk("stA_sin", {23'd0, io.out_sin}, 32'h034);
    mx = 8'h99;
    my = 8'h77;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stA_hold_vld", {31'd0, io.out_valid}, 32'd1);
      chk("stA_hold_rdy", {31'd0, io.in_ready}, 32'd0);
      chk("stA_hold_res", {14'd0, io.out_cos, io.out_sin, io.out_err}, {14'd0, 9'h012, 9'h034, 1'b0});
    end
    accept("stA");
    chk("stB_done_high", {31'd0, io.core_done}, 32'd1);
    op("stB", 2'd1, 8'h22, 8'h33, 8'h44, 8, 9'h1BC, 9'h033, 1'b0, 3);

    // Reset in the middle of WAIT.
    sticky = 1'b0;
    lat = -1;
    send(2'd3, 8'h55);
    repeat (6) @(negedge clk);
    chk("mid_target", {24'd0, io.core_target}, 32'h55);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", {31'd0, io.in_ready}, 32'd1);
    chk("mid_rst_out_valid", {31'd0, io.out_valid}, 32'd0);
    chk("mid_rst_core_start", {31'd0, io.core_start}, 32'd0);
    chk("mid_rst_target", {24'd0, io.core_target}, 32'd0);
    chk("mid_rst_cos_sin_err", {14'd0, io.out_cos, io.out_sin, io.out_err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    op("post", 2'd0, 8'h01, 8'h07, 8'h08, 2, 9'h007, 9'h008, 1'b0, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
